// File: rtl/ram_time_mux_pkg.sv
// Shared definitions for ram_time_mux: slot encoding, read-tag record and
// the legal RD_LATENCY range.
package ram_time_mux_pkg;

  typedef enum logic {
    SLOT_A = 1'b0,
    SLOT_B = 1'b1
  } slot_e;

  typedef struct packed {
    logic  valid;
    slot_e port;
  } tag_t;

  localparam int unsigned RD_LATENCY_MIN = 1;
  localparam int unsigned RD_LATENCY_MAX = 4;

endpackage

// File: rtl/ram_time_mux_tagpipe.sv
// Tag shift register following each issued read through the RAM latency and
// raising the owning port's latch enable when the data reaches the RAM output.
module ram_time_mux_tagpipe
  import ram_time_mux_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic clock_in,
  input  logic reset_in,
  input  logic issue_vld,
  input  logic issue_port,
  output logic a_latch_en_out,
  output logic b_latch_en_out
);

  if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
    $error("ram_time_mux_tagpipe: RD_LATENCY outside legal range");
  end

  tag_t pipe_r [RD_LATENCY];

  // Input is the registered RAM strobe, so the tail is reached on the cycle
  // before the data appears and the registered enable lines up with it.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      for (int unsigned i = 0; i < RD_LATENCY; i++) pipe_r[i] <= '0;
      a_latch_en_out <= 1'b0;
      b_latch_en_out <= 1'b0;
    end else begin
      pipe_r[0].valid <= issue_vld;
      pipe_r[0].port  <= slot_e'(issue_port);
      for (int unsigned i = 1; i < RD_LATENCY; i++) pipe_r[i] <= pipe_r[i-1];
      a_latch_en_out <= pipe_r[RD_LATENCY-1].valid && (pipe_r[RD_LATENCY-1].port == SLOT_A);
      b_latch_en_out <= pipe_r[RD_LATENCY-1].valid && (pipe_r[RD_LATENCY-1].port == SLOT_B);
    end
  end

endmodule

// File: rtl/ram_time_mux.sv
// Two-port time multiplexer driving a single-port RAM at twice the requester
// rate. Optional protocol checking is built when RAM_TIME_MUX_ERR_EN is defined.
module ram_time_mux
  import ram_time_mux_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned RD_LATENCY = 2
) (
  input  logic                  clock_in,
  input  logic                  reset_in,
  output logic                  phase_out,
  input  logic                  a_rd_in,
  input  logic                  a_wr_in,
  input  logic [ADDR_WIDTH-1:0] a_addr_in,
  input  logic [DATA_WIDTH-1:0] a_wdata_in,
  input  logic                  b_rd_in,
  input  logic                  b_wr_in,
  input  logic [ADDR_WIDTH-1:0] b_addr_in,
  input  logic [DATA_WIDTH-1:0] b_wdata_in,
  output logic [ADDR_WIDTH-1:0] ram_addr_out,
  output logic                  ram_rd_out,
  output logic                  ram_wr_out,
  output logic [DATA_WIDTH-1:0] ram_wdata_out,
  output logic                  a_latch_en_out,
  output logic                  b_latch_en_out,
  output logic                  a_rdata_vld_out,
  output logic                  b_rdata_vld_out,
  output logic                  err_out
);

  logic                  phase_r;
  logic                  ram_port_r;
  logic                  sel_rd;
  logic                  sel_wr;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  a_vld_hold_r;
  logic                  b_vld_hold_r;

  assign phase_out = phase_r;

  always_comb begin
    sel_rd    = b_rd_in;
    sel_wr    = b_wr_in;
    sel_addr  = b_addr_in;
    sel_wdata = b_wdata_in;
    if (phase_r == SLOT_A) begin
      sel_rd    = a_rd_in;
      sel_wr    = a_wr_in;
      sel_addr  = a_addr_in;
      sel_wdata = a_wdata_in;
    end
  end

  // A write wins over a read on the same port; the read is dropped.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      phase_r       <= SLOT_A;
      ram_port_r    <= SLOT_A;
      ram_rd_out    <= 1'b0;
      ram_wr_out    <= 1'b0;
      ram_addr_out  <= '0;
      ram_wdata_out <= '0;
    end else begin
      phase_r    <= ~phase_r;
      ram_port_r <= phase_r;
      ram_rd_out <= sel_rd & ~sel_wr;
      ram_wr_out <= sel_wr;
      if (sel_rd || sel_wr) ram_addr_out <= sel_addr;
      if (sel_wr) ram_wdata_out <= sel_wdata;
    end
  end

  ram_time_mux_tagpipe #(
    .RD_LATENCY (RD_LATENCY)
  ) u_tagpipe (
    .clock_in       (clock_in),
    .reset_in       (reset_in),
    .issue_vld      (ram_rd_out),
    .issue_port     (ram_port_r),
    .a_latch_en_out (a_latch_en_out),
    .b_latch_en_out (b_latch_en_out)
  );

  // Valid spans the two cycles after each latch enable; a new enable restarts it.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      a_rdata_vld_out <= 1'b0;
      b_rdata_vld_out <= 1'b0;
      a_vld_hold_r    <= 1'b0;
      b_vld_hold_r    <= 1'b0;
    end else begin
      a_rdata_vld_out <= a_latch_en_out | a_vld_hold_r;
      a_vld_hold_r    <= a_latch_en_out;
      b_rdata_vld_out <= b_latch_en_out | b_vld_hold_r;
      b_vld_hold_r    <= b_latch_en_out;
    end
  end

`ifdef RAM_TIME_MUX_ERR_EN
  localparam int unsigned REQ_W = 2 + ADDR_WIDTH + DATA_WIDTH;

  logic [REQ_W-1:0] a_req;
  logic [REQ_W-1:0] b_req;
  logic [REQ_W-1:0] a_snap_r;
  logic [REQ_W-1:0] b_snap_r;
  logic             a_seen_r;
  logic             b_seen_r;
  logic             err_r;

  assign a_req   = {a_rd_in, a_wr_in, a_addr_in, a_wdata_in};
  assign b_req   = {b_rd_in, b_wr_in, b_addr_in, b_wdata_in};
  assign err_out = err_r;

  // Each port is re-checked at its off-phase edge against what was sampled.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      a_snap_r <= '0;
      b_snap_r <= '0;
      a_seen_r <= 1'b0;
      b_seen_r <= 1'b0;
      err_r    <= 1'b0;
    end else if (phase_r == SLOT_A) begin
      a_snap_r <= a_req;
      a_seen_r <= 1'b1;
      if ((a_rd_in && a_wr_in) || (b_seen_r && (b_req != b_snap_r))) err_r <= 1'b1;
    end else begin
      b_snap_r <= b_req;
      b_seen_r <= 1'b1;
      if ((b_rd_in && b_wr_in) || (a_seen_r && (a_req != a_snap_r))) err_r <= 1'b1;
    end
  end
`else
  assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_ram_time_mux.sv
// Bench for ram_time_mux: three instances (RD_LATENCY 1, 2, 4) share stimulus
// and are compared each cycle against a request-history model and a RAM model.
module tb_ram_time_mux;

  localparam int AW   = 10;
  localparam int DW   = 32;
  localparam int NI   = 3;
  localparam int NMAX = 2048;

  function automatic int lat(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 4;
  endfunction

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_rd = 1'b0, a_wr = 1'b0, b_rd = 1'b0, b_wr = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;

  logic          phase_o [NI];
  logic [AW-1:0] raddr   [NI];
  logic          rrd     [NI];
  logic          rwr     [NI];
  logic [DW-1:0] rwdata  [NI];
  logic          le_a    [NI];
  logic          le_b    [NI];
  logic          vld_a   [NI];
  logic          vld_b   [NI];
  logic          err_o   [NI];

  always #5 clk = ~clk;

  ram_time_mux #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1)) u_l1 (
    .clock_in(clk), .reset_in(rst), .phase_out(phase_o[0]),
    .a_rd_in(a_rd), .a_wr_in(a_wr), .a_addr_in(a_addr), .a_wdata_in(a_wdata),
    .b_rd_in(b_rd), .b_wr_in(b_wr), .b_addr_in(b_addr), .b_wdata_in(b_wdata),
    .ram_addr_out(raddr[0]), .ram_rd_out(rrd[0]), .ram_wr_out(rwr[0]), .ram_wdata_out(rwdata[0]),
    .a_latch_en_out(le_a[0]), .b_latch_en_out(le_b[0]),
    .a_rdata_vld_out(vld_a[0]), .b_rdata_vld_out(vld_b[0]), .err_out(err_o[0]));

  ram_time_mux #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2)) u_l2 (
    .clock_in(clk), .reset_in(rst), .phase_out(phase_o[1]),
    .a_rd_in(a_rd), .a_wr_in(a_wr), .a_addr_in(a_addr), .a_wdata_in(a_wdata),
    .b_rd_in(b_rd), .b_wr_in(b_wr), .b_addr_in(b_addr), .b_wdata_in(b_wdata),
    .ram_addr_out(raddr[1]), .ram_rd_out(rrd[1]), .ram_wr_out(rwr[1]), .ram_wdata_out(rwdata[1]),
    .a_latch_en_out(le_a[1]), .b_latch_en_out(le_b[1]),
    .a_rdata_vld_out(vld_a[1]), .b_rdata_vld_out(vld_b[1]), .err_out(err_o[1]));

  ram_time_mux #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(4)) u_l4 (
    .clock_in(clk), .reset_in(rst), .phase_out(phase_o[2]),
    .a_rd_in(a_rd), .a_wr_in(a_wr), .a_addr_in(a_addr), .a_wdata_in(a_wdata),
    .b_rd_in(b_rd), .b_wr_in(b_wr), .b_addr_in(b_addr), .b_wdata_in(b_wdata),
    .ram_addr_out(raddr[2]), .ram_rd_out(rrd[2]), .ram_wr_out(rwr[2]), .ram_wdata_out(rwdata[2]),
    .a_latch_en_out(le_a[2]), .b_latch_en_out(le_b[2]),
    .a_rdata_vld_out(vld_a[2]), .b_rdata_vld_out(vld_b[2]), .err_out(err_o[2]));

  // Behavioural single-port RAM per instance: data appears RD_LATENCY cycles
  // after the edge that samples the read strobe.
  logic [DW-1:0] mem   [NI][1024];
  logic [DW-1:0] rpipe [NI][5];

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (rwr[i]) mem[i][raddr[i]] <= rwdata[i];
      rpipe[i][0] <= rrd[i] ? mem[i][raddr[i]] : 'x;
      for (int k = 1; k < 5; k++) rpipe[i][k] <= rpipe[i][k-1];
    end
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  int            n;
  bit            h_rd    [NMAX];
  bit            h_port  [NMAX];
  logic [DW-1:0] h_data  [NMAX];
  bit            h_known [NMAX];
  bit            h_le    [NI][2][NMAX];
  logic [DW-1:0] mdl_mem   [1024];
  bit            mdl_known [1024];
  logic          exp_rd, exp_wr, exp_err;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_wdata;
  bit            a_seen, b_seen;
  logic [AW+DW+1:0] a_last, b_last;
  int            le_cnt [NI][2];

  task automatic chk(input string tag, input int inst, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s[lat%0d] n=%0d observed=%h expected=%h", tag, lat(inst), n, obs, expv);
    end
  endtask

  task automatic model_reset();
    n = 0;
    for (int k = 0; k < NMAX; k++) begin
      h_rd[k] = 0; h_port[k] = 0; h_known[k] = 0;
      for (int i = 0; i < NI; i++) begin h_le[i][0][k] = 0; h_le[i][1][k] = 0; end
    end
    exp_rd = 0; exp_wr = 0; exp_err = 0; exp_addr = '0; exp_wdata = '0;
    a_seen = 0; b_seen = 0; a_last = '0; b_last = '0;
  endtask

  task automatic step();
    bit p, rd, wr, le_x[2], vx;
    logic [AW-1:0] ad;
    logic [DW-1:0] wd;
    logic [AW+DW+1:0] av, bv;
    int m;
    @(posedge clk);
    av = {a_rd, a_wr, a_addr, a_wdata};
    bv = {b_rd, b_wr, b_addr, b_wdata};
    p = n[0];
    {rd, wr, ad, wd} = p ? bv : av;
    if (n + 1 >= NMAX) begin
      $display("FAIL model_overflow n=%0d", n);
      $fatal(1, "model history exhausted");
    end
    n++;
    exp_rd = rd & ~wr;
    exp_wr = wr;
    if (rd || wr) exp_addr = ad;
    if (wr) begin exp_wdata = wd; mdl_mem[ad] = wd; mdl_known[ad] = 1; end
    h_rd[n] = exp_rd;
    h_port[n] = p;
    if (exp_rd) begin h_data[n] = mdl_mem[ad]; h_known[n] = mdl_known[ad]; end
`ifdef RAM_TIME_MUX_ERR_EN
    if (rd && wr) exp_err = 1;
    if (!p) begin
      if (b_seen && bv != b_last) exp_err = 1;
      a_seen = 1; a_last = av;
    end else begin
      if (a_seen && av != a_last) exp_err = 1;
      b_seen = 1; b_last = bv;
    end
`endif
    #2;
    for (int i = 0; i < NI; i++) begin
      m = n - 1 - lat(i);
      for (int q = 0; q < 2; q++) begin
        le_x[q] = (m >= 1) && h_rd[m] && (h_port[m] == q[0]);
        h_le[i][q][n] = le_x[q];
      end
      chk("phase", i, DW'(phase_o[i]), DW'(n % 2));
      chk("ram_rd", i, DW'(rrd[i]), DW'(exp_rd));
      chk("ram_wr", i, DW'(rwr[i]), DW'(exp_wr));
      chk("ram_addr", i, DW'(raddr[i]), DW'(exp_addr));
      chk("ram_wdata", i, rwdata[i], exp_wdata);
      chk("a_latch_en", i, DW'(le_a[i]), DW'(le_x[0]));
      chk("b_latch_en", i, DW'(le_b[i]), DW'(le_x[1]));
      chk("le_exclusive", i, DW'(le_a[i] & le_b[i]), '0);
      vx = h_le[i][0][n-1] | ((n >= 2) ? h_le[i][0][n-2] : 1'b0);
      chk("a_rdata_vld", i, DW'(vld_a[i]), DW'(vx));
      vx = h_le[i][1][n-1] | ((n >= 2) ? h_le[i][1][n-2] : 1'b0);
      chk("b_rdata_vld", i, DW'(vld_b[i]), DW'(vx));
      chk("err", i, DW'(err_o[i]), DW'(exp_err));
      if ((le_x[0] || le_x[1]) && h_known[m]) chk("rdata", i, rpipe[i][lat(i)], h_data[m]);
      if (le_a[i]) le_cnt[i][0]++;
      if (le_b[i]) le_cnt[i][1]++;
    end
    #1;
  endtask

  // One slow period: A request for two cycles, B request offset by one cycle.
  task automatic period(input logic [1:0] aop, input logic [AW-1:0] aad, input logic [DW-1:0] awd,
                        input logic [1:0] bop, input logic [AW-1:0] bad, input logic [DW-1:0] bwd);
    {a_wr, a_rd} = aop; a_addr = aad; a_wdata = awd;
    step();
    {b_wr, b_rd} = bop; b_addr = bad; b_wdata = bwd;
    step();
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_phase"}, i, DW'(phase_o[i]), '0);
      chk({tag, "_ram_ctl"}, i, DW'({rrd[i], rwr[i]}), '0);
      chk({tag, "_ram_addr"}, i, DW'(raddr[i]), '0);
      chk({tag, "_ram_wdata"}, i, rwdata[i], '0);
      chk({tag, "_latch_en"}, i, DW'({le_a[i], le_b[i]}), '0);
      chk({tag, "_vld"}, i, DW'({vld_a[i], vld_b[i]}), '0);
      chk({tag, "_err"}, i, DW'(err_o[i]), '0);
    end
  endtask

  // Called right after a step (posedge+3): reset lands mid-cycle.
  task automatic do_reset();
    #2 rst = 1'b1;
    {a_rd, a_wr, b_rd, b_wr} = '0;
    #1 chk_all_zero("reset");
    @(posedge clk);
    #4 rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    for (int i = 0; i < NI; i++) begin le_cnt[i][0] = 0; le_cnt[i][1] = 0; end
    #2 chk_all_zero("por");
    #20 rst = 1'b0;

    // A read of 0x010 with idle B, then drain
    period(2'b01, 10'h010, '0, 2'b00, '0, '0);
    repeat (4) period(2'b00, '0, '0, 2'b00, '0, '0);

    // A writes 0xDEADBEEF to 0x020, B reads 0x020 in the same slow period
    period(2'b10, 10'h020, 32'hDEADBEEF, 2'b01, 10'h020, '0);
    repeat (4) period(2'b00, '0, '0, 2'b00, '0, '0);

    // Back-to-back reads on both ports for 16 slow periods
    for (int i = 0; i < NI; i++) begin le_cnt[i][0] = 0; le_cnt[i][1] = 0; end
    for (int k = 0; k < 16; k++)
      period(2'b01, AW'($urandom_range(0, 63)), '0, 2'b01, AW'($urandom_range(0, 63)), '0);
    repeat (4) period(2'b00, '0, '0, 2'b00, '0, '0);
    for (int i = 0; i < NI; i++) begin
      chk("b2b_a_count", i, DW'(le_cnt[i][0]), 32'd16);
      chk("b2b_b_count", i, DW'(le_cnt[i][1]), 32'd16);
    end

    // Reset while reads are in flight, then confirm nothing emerges
    period(2'b01, 10'h005, '0, 2'b01, 10'h006, '0);
    do_reset();
    for (int i = 0; i < NI; i++) begin le_cnt[i][0] = 0; le_cnt[i][1] = 0; end
    repeat (5) period(2'b00, '0, '0, 2'b00, '0, '0);
    for (int i = 0; i < NI; i++) chk("post_reset_le", i, DW'(le_cnt[i][0] + le_cnt[i][1]), '0);

    // Randomized traffic over a small address window
    repeat (150)
      period(2'($urandom_range(0, 3)), AW'($urandom_range(0, 15)), DW'($urandom),
             2'($urandom_range(0, 3)), AW'($urandom_range(0, 15)), DW'($urandom));
    repeat (4) period(2'b00, '0, '0, 2'b00, '0, '0);

`ifdef RAM_TIME_MUX_ERR_EN
    // rd+wr together on A: write issued, no latch enable, sticky error
    do_reset();
    period(2'b11, 10'h003, 32'h12345678, 2'b00, '0, '0);
    repeat (4) period(2'b00, '0, '0, 2'b00, '0, '0);
    // Error clears on reset; then A changes its address mid slow period
    do_reset();
    {a_wr, a_rd} = 2'b01; a_addr = 10'h007;
    step();
    a_addr = 10'h008;
    step();
    repeat (3) period(2'b00, '0, '0, 2'b00, '0, '0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_time_mux.md
# ram_time_mux

Two-port time-multiplexer that runs a single-port RAM at twice the requester rate. Port A is served on even cycles and port B on odd cycles. The block drives the RAM address, control and write-data lines. It tracks every read through the RAM latency and generates the per-port enable for the downstream synchronous latches that hold read data stable for the half-rate consumers.

## Interface
Parameters:
- ADDR_WIDTH, 10, RAM address width
- DATA_WIDTH, 32, RAM data width
- RD_LATENCY, 2, RAM read latency in cycles; legal range 1..4

Ports:
- clock_in  in  1  fast clock (2x requester rate)
- reset_in  in  1  asynchronous, active-high reset
- phase_out  out  1  current slot: 0 = port A, 1 = port B
- a_rd_in / b_rd_in  in  1  read request
- a_wr_in / b_wr_in  in  1  write request
- a_addr_in / b_addr_in  in  ADDR_WIDTH  request address
- a_wdata_in / b_wdata_in  in  DATA_WIDTH  write data
- ram_addr_out  out  ADDR_WIDTH  RAM address
- ram_rd_out  out  1  RAM read strobe
- ram_wr_out  out  1  RAM write strobe
- ram_wdata_out  out  DATA_WIDTH  RAM write data
- a_latch_en_out / b_latch_en_out  out  1  enable for the port's downstream latch; high in the cycle its read data is on the RAM output
- a_rdata_vld_out / b_rdata_vld_out  out  1  latched read data valid for the port
- err_out  out  1  sticky protocol error (see Configuration)

## Operation
- phase_r toggles every cycle. phase_out = phase_r.
- Requests:
  - Requesters hold inputs stable for two cycles, aligned to phase.
  - A's inputs are sampled at the edge where phase_r = 0.
  - B's inputs are sampled at the edge where phase_r = 1.
- Sampled request is registered onto ram_* outputs for exactly one cycle.
  - ram_rd_out/ram_wr_out are 0 when the sampled port has no request.
  - ram_addr_out/ram_wdata_out hold their previous value when idle.
- rd and wr both high on one port: the write is issued and the read is dropped. The error is flagged if enabled.
- Tag pipeline: a shift register of depth RD_LATENCY carrying {valid, port} per issued read, one entry per cycle.
- Latch enable:
  - The entry at the pipeline tail with valid = 1 and port = A asserts a_latch_en_out for one cycle.
  - Same rule for B and b_latch_en_out.
  - That cycle is exactly when ram_rdata_in carries the data.
  - Both enables are registered and never both high.
- rdata_vld:
  - Asserted for 2 cycles, starting the cycle after the latch enable falls.
  - A new latch enable for the same port during that window restarts the 2-cycle count.
- No back-pressure: every issued read produces exactly one latch enable.
- Same-address A write followed by B read in one slow period: B returns the new data. RAM ordering guarantees this; the block does no forwarding.

## Timing
- Reset values:
  - phase_r = 0 and all outputs = 0.
  - Tag pipeline cleared; err_out = 0.
- Request-to-RAM latency: 1 cycle after the sampling edge.
- Request-to-latch-enable latency: 1 + RD_LATENCY cycles after the sampling edge.
- Request-to-valid latency: 2 + RD_LATENCY cycles after the sampling edge. Valid stays high 2 cycles.
- Throughput: one access per port per 2 cycles; RAM busy 100% when both ports are active.
- Reset asserted mid-operation:
  - In-flight reads are discarded.
  - No latch enable or valid is produced after reset release for reads issued before reset.
- First sampling edge after reset release is port A.

## Configuration
- RAM_TIME_MUX_ERR_EN defined:
  - err_out sets on simultaneous rd+wr on one port.
  - err_out also sets when a port's inputs change between the two cycles of its slow period, checked at the off-phase edge.
  - err_out clears only on reset.
- RAM_TIME_MUX_ERR_EN undefined: err_out tied to 0 and the checking logic is absent.

## Structure
- Shared package holds:
  - the slot encoding constants SLOT_A = 0, SLOT_B = 1
  - the tag record type {valid, port}
  - RD_LATENCY legal bounds
- One sub-module, ram_time_mux_tagpipe: the parameterised tag shift register producing the per-port latch enables.
- Port muxing and the phase counter stay in the top module.

## Test plan
- Reset mid-read: reset asserted while a read is in the tag pipeline → all outputs 0, and no latch enable after release.
- A read addr 0x010, RD_LATENCY = 2:
  - ram_rd_out = 1 with ram_addr_out = 0x010 one cycle after the phase-0 edge.
  - a_latch_en_out = 1 three cycles after that edge.
  - a_rdata_vld_out high for the following 2 cycles.
- Same-slow-period access, both addressing 0x020:
  - A writes 0xDEADBEEF and B reads.
  - ram_wr_out in the slot-A cycle, then ram_rd_out in the next cycle.
  - b_latch_en_out fires; the latched data = 0xDEADBEEF.
- Back-to-back reads on both ports for 16 slow periods → alternating a/b latch enables, never simultaneous, 16 valid windows each.
- With RAM_TIME_MUX_ERR_EN: A rd+wr together → write issued, no A latch enable, err_out = 1 and held until reset.
- Sweep RD_LATENCY = 1 and 4 → latch enable at 2 and 5 cycles after the sampling edge respectively.
